// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: LSU size codes, port ids,
// the access-engine state encoding and the alignment rule.
package mem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Which initiator owns the request currently in flight.
  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size 3 is illegal; halves need an even lane; words need lane 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'd0);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// IFU and LSU request/response bundle between the core and the memory.
//
// Handshake: an initiator raises reqValid with its fields and holds all of
// them stable until it sees its own respValid (a one-cycle strobe). The
// responder only samples requests while idle; a reqValid still high in the
// cycle after respValid counts as a new request, so an initiator that wants
// exactly one access drops reqValid as soon as respValid appears. io_err is
// only ever high together with one of the respValid strobes.
interface mem_responder_if;

  logic        io_ifu_reqValid;
  logic [31:0] io_ifu_addr;
  logic        io_ifu_respValid;
  logic [31:0] io_ifu_rdata;

  logic        io_lsu_reqValid;
  logic [31:0] io_lsu_addr;
  logic [1:0]  io_lsu_size;
  logic        io_lsu_wen;
  logic [31:0] io_lsu_wdata;
  logic [3:0]  io_lsu_wmask;
  logic        io_lsu_respValid;
  logic [31:0] io_lsu_rdata;

  logic        io_err;

  // Core side: issues requests, receives responses.
  modport master (
    output io_ifu_reqValid, io_ifu_addr,
    input  io_ifu_respValid, io_ifu_rdata,
    output io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen,
    output io_lsu_wdata, io_lsu_wmask,
    input  io_lsu_respValid, io_lsu_rdata,
    input  io_err
  );

  // Memory side: receives requests, produces responses.
  modport slave (
    input  io_ifu_reqValid, io_ifu_addr,
    output io_ifu_respValid, io_ifu_rdata,
    input  io_lsu_reqValid, io_lsu_addr, io_lsu_size, io_lsu_wen,
    input  io_lsu_wdata, io_lsu_wmask,
    output io_lsu_respValid, io_lsu_rdata,
    output io_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering between right-justified LSU data and a stored word:
// shifts store data/mask up to the addressed lane and brings load data down,
// zero-filling above the access size.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wmask,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata_sh,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_rshift;

  assign o_byte_en  = i_wmask << i_lane;
  assign o_wdata_sh = i_wdata << {i_lane, 3'b000};
  assign w_rshift   = i_rword >> {i_lane, 3'b000};
  assign o_misalign = is_misaligned(i_size, i_lane);

  // Keep only the bytes covered by the access size.
  always_comb begin
    o_rdata = '0;
    case (i_size)
      SIZE_BYTE: o_rdata = {24'd0, w_rshift[7:0]};
      SIZE_HALF: o_rdata = {16'd0, w_rshift[15:0]};
      SIZE_WORD: o_rdata = w_rshift;
      default:   o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Backing memory for the multicycle core. One word-wide array is shared by a
// read-only IFU port and a sized read/write LSU port through a single access
// engine: IDLE accepts one request (LSU wins ties), BUSY counts down the
// configured latency and performs the array access on its last cycle, RESP
// presents a one-cycle response on the owning port.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH   = 4096,           // 32-bit words, power of two
  parameter logic [31:0] BASE    = 32'h8000_0000,  // byte address of word 0
  parameter int          LATENCY = 1               // acceptance to respValid minus one, >= 1
) (
  input  logic             clock,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output state_t           o_dbg_state
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam int          CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);

  // Engine state.
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_acc_lsu;
  logic             w_acc_ifu;
  logic             w_access;

  // Latched request.
  logic        r_port;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_wen;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;

  // Response registers.
  logic [31:0] r_rdata;
  logic        r_err;

  // Storage and decode.
  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      w_off;
  logic             w_oob;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_align_rdata;
  logic             w_misalign;
  logic             w_err;
  logic             w_do_write;
  logic             w_resp;

  // Unsigned subtraction makes addresses below BASE wrap to huge offsets,
  // so one compare covers both ends of the window.
  assign w_off   = r_addr - BASE;
  assign w_oob   = (w_off >= SPAN);
  assign w_idx   = w_off[IDX_W+1:2];
  assign w_rword = r_mem[w_idx];

  // IFU requests are latched as word-sized with no write, so the same
  // alignment check enforces the IFU word-alignment rule.
  mem_lane_align u_align (
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_wmask    (r_wmask),
    .i_rword    (w_rword),
    .o_byte_en  (w_be),
    .o_wdata_sh (w_wdata_sh),
    .o_rdata    (w_align_rdata),
    .o_misalign (w_misalign)
  );

  assign w_err      = w_oob || w_misalign;
  assign w_do_write = w_access && r_wen && !w_err;

  // State and latency counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Arbitration, latency countdown and access timing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_lsu   = 1'b0;
    w_acc_ifu   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.io_lsu_reqValid) begin
          w_acc_lsu   = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = ST_BUSY;
        end else if (bus.io_ifu_reqValid) begin
          w_acc_ifu   = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the accepted request; it stays put until the next acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_port  <= PORT_IFU;
      r_addr  <= '0;
      r_size  <= SIZE_WORD;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_acc_lsu) begin
      r_port  <= PORT_LSU;
      r_addr  <= bus.io_lsu_addr;
      r_size  <= bus.io_lsu_size;
      r_wen   <= bus.io_lsu_wen;
      r_wdata <= bus.io_lsu_wdata;
      r_wmask <= bus.io_lsu_wmask;
    end else if (w_acc_ifu) begin
      r_port  <= PORT_IFU;
      r_addr  <= bus.io_ifu_addr;
      r_size  <= SIZE_WORD;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end
  end

  // Register the response data and error flag on the access cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err <= w_err;
      if (w_err || r_wen) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= w_align_rdata;
      end
    end
  end

  // Byte-enabled array write on the BUSY->RESP edge; contents are never reset.
  always_ff @(posedge clock) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign w_resp               = (r_state == ST_RESP);
  assign bus.io_ifu_respValid = w_resp && (r_port == PORT_IFU);
  assign bus.io_lsu_respValid = w_resp && (r_port == PORT_LSU);
  assign bus.io_ifu_rdata     = bus.io_ifu_respValid ? r_rdata : '0;
  assign bus.io_lsu_rdata     = bus.io_lsu_respValid ? r_rdata : '0;
  assign bus.io_err           = w_resp && r_err;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=1 instance for function and a
// LATENCY=4 instance for timing. Drivers push expected responses
// {port, err, rdata, cycle} into queues; per-instance monitors pop and
// compare whenever a respValid strobe appears.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          W     = 66;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = 32'd0;
  int          total = 0;
  int          bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp4_q[$];
  logic [31:0]  ref_mem [int];

  state_t dbg1;
  state_t dbg4;

  mem_responder_if bus();
  mem_responder_if bus4();

  mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut (
    .clock(clk), .reset(rst_n), .bus(bus), .o_dbg_state(dbg1)
  );

  mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) u_dut4 (
    .clock(clk), .reset(rst_n), .bus(bus4), .o_dbg_state(dbg4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_item(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    check({tag, "_port"},  32'(got[65]), 32'(exp[65]));
    check({tag, "_err"},   32'(got[64]), 32'(exp[64]));
    check({tag, "_rdata"}, got[63:32],   exp[63:32]);
    check({tag, "_cycle"}, got[31:0],    exp[31:0]);
  endtask

  // ---------------- reference model ----------------
  // Byte-oriented view of memory: a word is four independent bytes; an
  // access touches bytes lane .. lane+nbytes-1 of one word.
  task automatic model_lsu(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           output logic err, output logic [31:0] rd);
    longint      off;
    int          idx;
    int          lane;
    int          nbytes;
    logic [31:0] w;
    off  = longint'(addr) - longint'(BASE);
    lane = int'(addr[1:0]);
    rd   = 32'd0;
    err  = (off < 0) || (off >= 4 * DEPTH) || (size == 2'd3) ||
           (size == SIZE_HALF && (lane % 2) == 1) || (size == SIZE_WORD && lane != 0);
    if (err) return;
    idx = int'(off / 4);
    w   = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    if (wen) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b] && (lane + b) < 4) w[8*(lane+b) +: 8] = wdata[8*b +: 8];
      end
      ref_mem[idx] = w;
    end else begin
      nbytes = 1 << size;
      for (int b = 0; b < nbytes; b++) rd[8*b +: 8] = w[8*(lane+b) +: 8];
    end
  endtask

  task automatic model_ifu(input logic [31:0] addr, output logic err, output logic [31:0] rd);
    longint off;
    off = longint'(addr) - longint'(BASE);
    rd  = 32'd0;
    err = (off < 0) || (off >= 4 * DEPTH) || (addr[1:0] != 2'd0);
    if (!err) rd = ref_mem.exists(int'(off / 4)) ? ref_mem[int'(off / 4)] : 32'd0;
  endtask

  // ---------------- drivers ----------------
  // which: 0 dut lsu, 1 dut ifu, 2 dut4 lsu, 3 dut4 ifu
  task automatic wait_resp(input int which, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      case (which)
        0: if (bus.io_lsu_respValid)  return;
        1: if (bus.io_ifu_respValid)  return;
        2: if (bus4.io_lsu_respValid) return;
        3: if (bus4.io_ifu_respValid) return;
        default: ;
      endcase
    end
    total++;
    bad++;
    $display("FAIL %s timeout: no respValid within 50 cycles, required one", name);
  endtask

  task automatic drive_lsu(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    bus.io_lsu_reqValid = 1'b1;
    bus.io_lsu_addr     = addr;
    bus.io_lsu_size     = size;
    bus.io_lsu_wen      = wen;
    bus.io_lsu_wdata    = wdata;
    bus.io_lsu_wmask    = wmask;
  endtask

  task automatic issue_lsu(input logic [31:0] addr, input logic [1:0] size, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    logic        err;
    logic [31:0] rd;
    @(negedge clk);
    drive_lsu(addr, size, wen, wdata, wmask);
    model_lsu(addr, size, wen, wdata, wmask, err, rd);
    exp_q.push_back({PORT_LSU, err, rd, cyc + 32'd2});
    wait_resp(0, "lsu_resp");
    bus.io_lsu_reqValid = 1'b0;
  endtask

  task automatic issue_ifu(input logic [31:0] addr);
    logic        err;
    logic [31:0] rd;
    @(negedge clk);
    bus.io_ifu_reqValid = 1'b1;
    bus.io_ifu_addr     = addr;
    model_ifu(addr, err, rd);
    exp_q.push_back({PORT_IFU, err, rd, cyc + 32'd2});
    wait_resp(1, "ifu_resp");
    bus.io_ifu_reqValid = 1'b0;
  endtask

  function automatic logic [31:0] oob_addr();
    case ($urandom_range(0, 3))
      0: return BASE - 32'(4 * $urandom_range(1, 8)) + 32'($urandom_range(0, 3));
      1: return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 40));
      2: return 32'($urandom_range(0, 255));
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  // ---------------- monitors / scoreboards ----------------
  always @(negedge clk) begin : mon1
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (bus.io_ifu_respValid || bus.io_lsu_respValid) begin
      got = {bus.io_lsu_respValid, bus.io_err,
             bus.io_lsu_respValid ? bus.io_lsu_rdata : bus.io_ifu_rdata, cyc};
      if (bus.io_ifu_respValid && bus.io_lsu_respValid) begin
        total++; bad++;
        $display("FAIL dut1_both_valid: both respValid high at cycle %0d, required at most one", cyc);
      end
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected: response at cycle %0d with no request pending", cyc);
      end else begin
        exp = exp_q.pop_front();
        cmp_item("dut1", got, exp);
      end
    end else if (bus.io_err) begin
      total++; bad++;
      $display("FAIL dut1_err_strobe: io_err=1 without respValid at cycle %0d, required 0", cyc);
    end
  end

  always @(negedge clk) begin : mon4
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (bus4.io_ifu_respValid || bus4.io_lsu_respValid) begin
      got = {bus4.io_lsu_respValid, bus4.io_err,
             bus4.io_lsu_respValid ? bus4.io_lsu_rdata : bus4.io_ifu_rdata, cyc};
      if (exp4_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dut4_unexpected: response at cycle %0d with no request pending", cyc);
      end else begin
        exp = exp4_q.pop_front();
        cmp_item("dut4", got, exp);
      end
    end else if (bus4.io_err) begin
      total++; bad++;
      $display("FAIL dut4_err_strobe: io_err=1 without respValid at cycle %0d, required 0", cyc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic        e1;
    logic        e2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] n;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wmask;

    rst_n = 1'b0;
    bus.io_ifu_reqValid  = 1'b0; bus.io_ifu_addr  = '0;
    bus.io_lsu_reqValid  = 1'b0; bus.io_lsu_addr  = '0; bus.io_lsu_size  = '0;
    bus.io_lsu_wen       = 1'b0; bus.io_lsu_wdata = '0; bus.io_lsu_wmask = '0;
    bus4.io_ifu_reqValid = 1'b0; bus4.io_ifu_addr = '0;
    bus4.io_lsu_reqValid = 1'b0; bus4.io_lsu_addr = '0; bus4.io_lsu_size = '0;
    bus4.io_lsu_wen      = 1'b0; bus4.io_lsu_wdata = '0; bus4.io_lsu_wmask = '0;

    // Reset state: every output low.
    repeat (3) @(negedge clk);
    check("rst_ifu_respValid", 32'(bus.io_ifu_respValid), 32'd0);
    check("rst_lsu_respValid", 32'(bus.io_lsu_respValid), 32'd0);
    check("rst_err",           32'(bus.io_err),           32'd0);
    check("rst_ifu_rdata",     bus.io_ifu_rdata,          32'd0);
    check("rst_lsu_rdata",     bus.io_lsu_rdata,          32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Store word then load it back.
    issue_lsu(32'h8000_0004, SIZE_WORD, 1'b1, 32'hCAFE_BABE, 4'hF);
    issue_lsu(32'h8000_0004, SIZE_WORD, 1'b0, 32'd0, 4'h0);

    // Byte lanes: seed a word, overwrite its top byte, read word and byte.
    issue_lsu(32'h8000_0010, SIZE_WORD, 1'b1, 32'h1122_3344, 4'hF);
    issue_lsu(32'h8000_0013, SIZE_BYTE, 1'b1, 32'hFFFF_FF5A, 4'h1);
    issue_lsu(32'h8000_0010, SIZE_WORD, 1'b0, 32'd0, 4'h0);
    issue_lsu(32'h8000_0013, SIZE_BYTE, 1'b0, 32'd0, 4'h0);
    issue_lsu(32'h8000_0012, SIZE_HALF, 1'b0, 32'd0, 4'h0);

    // Arbitration: both ports in the same IDLE cycle.
    @(negedge clk);
    drive_lsu(32'h8000_0010, SIZE_WORD, 1'b0, 32'd0, 4'h0);
    bus.io_ifu_reqValid = 1'b1;
    bus.io_ifu_addr     = 32'h8000_0004;
    model_lsu(32'h8000_0010, SIZE_WORD, 1'b0, 32'd0, 4'h0, e1, r1);
    model_ifu(32'h8000_0004, e2, r2);
    n = cyc;
    exp_q.push_back({PORT_LSU, e1, r1, n + 32'd2});
    exp_q.push_back({PORT_IFU, e2, r2, n + 32'd5});
    wait_resp(0, "arb_lsu");
    bus.io_lsu_reqValid = 1'b0;
    wait_resp(1, "arb_ifu");
    bus.io_ifu_reqValid = 1'b0;

    // Errors: misaligned half load, store below BASE aliasing the last word.
    issue_lsu(32'h8000_0001, SIZE_HALF, 1'b0, 32'd0, 4'h0);
    issue_lsu(32'h8000_3FFC, SIZE_WORD, 1'b1, 32'h0BAD_F00D, 4'hF);
    issue_lsu(32'h7FFF_FFFC, SIZE_WORD, 1'b1, 32'h1234_5678, 4'hF);
    issue_lsu(32'h8000_3FFC, SIZE_WORD, 1'b0, 32'd0, 4'h0);
    issue_lsu(32'h8000_0002, SIZE_WORD, 1'b0, 32'd0, 4'h0);
    issue_lsu(32'h8000_0000, 2'd3,      1'b0, 32'd0, 4'h0);
    issue_ifu(32'h8000_0006);
    issue_ifu(32'h8000_4000);

    // Reset during a store's BUSY cycle: no response, no write.
    @(negedge clk);
    drive_lsu(32'h8000_0004, SIZE_WORD, 1'b1, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_lsu_respValid", 32'(bus.io_lsu_respValid), 32'd0);
    check("midrst_ifu_respValid", 32'(bus.io_ifu_respValid), 32'd0);
    check("midrst_err",           32'(bus.io_err),           32'd0);
    check("midrst_lsu_rdata",     bus.io_lsu_rdata,          32'd0);
    bus.io_lsu_reqValid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue_lsu(32'h8000_0004, SIZE_WORD, 1'b0, 32'd0, 4'h0);

    // LATENCY=4 instance: seed word 0, then a held IFU request gives two fetches.
    @(negedge clk);
    bus4.io_lsu_reqValid = 1'b1;
    bus4.io_lsu_addr     = 32'h8000_0000;
    bus4.io_lsu_size     = SIZE_WORD;
    bus4.io_lsu_wen      = 1'b1;
    bus4.io_lsu_wdata    = 32'h1357_9BDF;
    bus4.io_lsu_wmask    = 4'hF;
    exp4_q.push_back({PORT_LSU, 1'b0, 32'd0, cyc + 32'd5});
    wait_resp(2, "lat4_store");
    bus4.io_lsu_reqValid = 1'b0;
    @(negedge clk);
    bus4.io_ifu_reqValid = 1'b1;
    bus4.io_ifu_addr     = 32'h8000_0000;
    n = cyc;
    exp4_q.push_back({PORT_IFU, 1'b0, 32'h1357_9BDF, n + 32'd5});
    exp4_q.push_back({PORT_IFU, 1'b0, 32'h1357_9BDF, n + 32'd11});
    wait_resp(3, "lat4_fetch1");
    wait_resp(3, "lat4_fetch2");
    bus4.io_ifu_reqValid = 1'b0;

    // Randomized traffic over a seeded 16-word region plus out-of-range hits.
    for (int i = 0; i < 16; i++) begin
      issue_lsu(BASE + 32'(4 * i), SIZE_WORD, 1'b1, $urandom, 4'hF);
    end
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 15) addr = oob_addr();
      else addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        issue_ifu(addr);
      end else begin
        size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        case (size)
          SIZE_BYTE: wmask = 4'h1;
          SIZE_HALF: wmask = 4'h3;
          SIZE_WORD: wmask = 4'hF;
          default:   wmask = 4'($urandom_range(0, 15));
        endcase
        issue_lsu(addr, size, 1'($urandom_range(0, 1)), $urandom, wmask);
      end
    end

    repeat (8) @(negedge clk);
    check("drain_dut1", 32'(exp_q.size()),  32'd0);
    check("drain_dut4", 32'(exp4_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
